// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Reads a block of consecutive words from one port of a BRAM that has a
//   registered read output (data valid one cycle after mem_en_o) and presents
//   them as a valid/ready stream, with tlast on the final word.
//   Sustains one word per cycle when tready is held high. Any number of
//   tready stalls causes no data loss: at most two words are ever owed to
//   the stream (buffered plus in flight).
//
// Ports
//   clk_i, rst_i          clock (also the BRAM port clock), async active-high reset
//   start_i               start a transfer (sampled only when idle)
//   base_addr_i, len_i    first word address and word count, captured with start_i
//   busy_o, done_o        transfer in progress / one-cycle completion pulse
//   mem_en_o, mem_wr_en_o BRAM enable (read-issue cycles only) / write enables (always 0)
//   mem_addr_o            BRAM read address
//   mem_data_i            BRAM read data, valid the cycle after mem_en_o
//   m_axis_*              output stream (tdata, tvalid, tready, tlast)
module bram_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_NUM   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_en_o,
    output logic [BYTE_NUM-1:0]   mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic                  m_axis_tlast_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;          // address of the next read to issue
    logic [LEN_WIDTH-1:0]  rem_q;           // words still to be issued
    logic                  inflight_q;      // a read was issued last cycle
    logic                  inflight_last_q; // ... and it was the final word

    // Two-entry FIFO; each entry carries {tlast, data}.
    logic [DATA_WIDTH:0] fifo_q [2];
    logic                wr_ptr_q, rd_ptr_q;
    logic [1:0]          count_q;

    logic [1:0]          occupancy, occ_after_pop;
    logic                pop, issue, last_issue, push, fifo_pop;
    logic [DATA_WIDTH:0] head;

    // Datapath control. The stream head is the oldest buffered word, or the
    // word arriving from the BRAM this cycle when the buffer is empty; this
    // bypass is what puts the first word on the stream the cycle its data
    // appears. If the bypassed word is not taken it is written into the
    // buffer, so tdata stays stable across the stall.
    always_comb begin
        // NOTE: every signal driven here gets a value before any branch, so
        // no path can leave one unassigned and infer a latch.
        head          = '0;
        occupancy     = count_q + {1'b0, inflight_q};
        pop           = 1'b0;
        occ_after_pop = occupancy;
        issue         = 1'b0;
        last_issue    = 1'b0;
        push          = 1'b0;
        fifo_pop      = 1'b0;

        if (count_q != 2'd0) begin
            head = fifo_q[rd_ptr_q];
        end else if (inflight_q) begin
            head = {inflight_last_q, mem_data_i};
        end

        pop           = (count_q != 2'd0 || inflight_q) && m_axis_tready_i;
        occ_after_pop = occupancy - {1'b0, pop};
        // Issuing only while fewer than two words would remain owed to the
        // stream bounds buffer + in-flight at two, yet still allows one issue
        // per cycle when each cycle also pops a word.
        issue         = (state_q == S_READ) && (occ_after_pop < 2'd2);
        last_issue    = issue && (rem_q == LEN_WIDTH'(1));
        push          = inflight_q && !(count_q == 2'd0 && pop);
        fifo_pop      = pop && (count_q != 2'd0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (len_i == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leaves on the cycle of the final handshake, so done_o
                // follows it directly.
                if (occ_after_pop == 2'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst_i) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            state_q <= state_d;

            if (state_q == S_IDLE && start_i) begin
                addr_q <= base_addr_i;
                rem_q  <= len_i;
            end else if (issue) begin
                rem_q <= rem_q - LEN_WIDTH'(1);
                // Hold the last issued address rather than stepping past the block.
                if (!last_issue) begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                end
            end

            inflight_q      <= issue;
            inflight_last_q <= last_issue;

            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (fifo_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, fifo_pop};
        end
    end

    // NOTE: the FIFO storage has no reset; count_q alone decides which entries
    // are valid, so clearing the data would only cost reset routing.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {inflight_last_q, mem_data_i};
        end
    end

    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = (state_q == S_DONE);
    assign mem_en_o        = issue;
    assign mem_wr_en_o     = '0;
    assign mem_addr_o      = addr_q;
    assign m_axis_tvalid_o = (count_q != 2'd0) || inflight_q;
    assign m_axis_tdata_o  = head[DATA_WIDTH-1:0];
    assign m_axis_tlast_o  = head[DATA_WIDTH];

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side companion for bram_true_dp: drives one BRAM port (clk/en/wr_en/addr, registered 1-cycle read data) and turns a block of consecutive words into a valid/ready stream with tlast.
- Sustains 1 word/cycle under no backpressure and loses no data under arbitrary tready stalls.
- Intended for DMA-style unloading of packet/sample buffers.

Parameters:
- DATA_WIDTH, 32, BRAM word width; must equal BYTE_NUM*BYTE_WIDTH of the attached RAM.
- BYTE_NUM, 4, width of the write-enable output; the output is always driven zero.
- ADDR_WIDTH, 32, BRAM address width.
- LEN_WIDTH, 16, width of the transfer length in words.

Ports:
- clk_i  in  1  clock; also drives the attached BRAM port clock.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  begin a transfer; sampled only in IDLE.
- base_addr_i  in  ADDR_WIDTH  first word address; captured with start_i.
- len_i  in  LEN_WIDTH  number of words; captured with start_i.
- busy_o  out  1  high from the cycle after an accepted start until the done cycle inclusive.
- done_o  out  1  one-cycle pulse at transfer end.
- mem_en_o  out  1  BRAM enable; high only in read-issue cycles.
- mem_wr_en_o  out  BYTE_NUM  constant zero.
- mem_addr_o  out  ADDR_WIDTH  BRAM read address.
- mem_data_i  in  DATA_WIDTH  BRAM read data, valid the cycle after mem_en_o.
- m_axis_tdata_o  out  DATA_WIDTH  stream data.
- m_axis_tvalid_o  out  1  stream valid.
- m_axis_tready_i  in  1  stream ready.
- m_axis_tlast_o  out  1  high on the final word of a transfer.

Behaviour:
- Reset: busy_o, done_o, mem_en_o, m_axis_tvalid_o and m_axis_tlast_o are 0; mem_addr_o and m_axis_tdata_o are 0; buffer is empty; FSM is IDLE.
- Reset applied mid-transfer aborts the transfer immediately, with no done pulse. Any read still in flight is discarded.

FSM states and transitions:
- IDLE: on start_i with len_i != 0, capture address and length, go to READ. On start_i with len_i == 0, go to DONE (no beats, no mem_en_o).
- READ: issue reads. After the read for the last word has been issued, go to DRAIN.
- DRAIN: wait until no read is in flight and the buffer is empty, then go to DONE.
- DONE: done_o=1 for exactly one cycle, busy_o still 1, then IDLE.
- start_i outside IDLE is ignored.

Read issue:
- Each issue cycle drives mem_en_o=1 and mem_addr_o=base+k, where k is the issue index (0..len-1).
- Addresses wrap modulo 2^ADDR_WIDTH.
- mem_data_i is captured into the buffer exactly one cycle after an issue.

Output buffer:
- 2-entry FIFO feeding the stream.
- Issue is allowed only when (buffered + in_flight - pop) < 2, where pop = tvalid & tready in the same cycle. This guarantees no overflow and gives back-to-back issue when tready is held high.

Stream rules:
- Once asserted, tvalid stays high and tdata/tlast stay stable until the handshake.
- Words leave the block in address order.
- tlast is 1 only on word len-1.

Latency:
- Accepted start at cycle 0 gives the first issue at cycle 1, data captured at cycle 2, and tvalid at cycle 2.
- With tready held at 1, the last beat is at cycle len+1 and done_o at cycle len+2 (len=1: beat at cycle 2, done at cycle 3).
- done_o is asserted the cycle after the final handshake.

Widths and boundaries:
- len_i = 2^LEN_WIDTH-1 must work.
- The internal remaining-words counter is LEN_WIDTH bits; the issue index never exceeds len-1.
- Simultaneous capture and pop on a full or single-entry buffer preserves ordering and count.

Test Plan:
- Base 0x10, len 4, tready=1, RAM[0x10..0x13]=A0..A3 → mem_en_o high on cycles 1-4 with addr 0x10..0x13; beats A0..A3 on cycles 2-5; tlast only on A3; done_o on cycle 6.
- Same transfer, tready low on cycles 2-6 then high → tvalid held with A0 stable; mem_en_o stops after at most 2 outstanding reads; all 4 words arrive in order with none lost or duplicated.
- Random 30% tready, len 100 → exactly 100 beats matching RAM contents, a single tlast, a single done_o pulse.
- len 0 with start → no mem_en_o, no tvalid; done_o one cycle after start; busy_o high only for that cycle.
- Base 0xFFFFFFFE, len 4 → addresses FFFFFFFE, FFFFFFFF, 0, 1.
- rst_i asserted mid-transfer (after 2 of 8 beats) → all outputs 0 asynchronously with no done_o; a new start then completes normally.
